// File: rtl/serial_adder_if.sv
// Handshake/operand bundle for the bit-serial adder.
// The requester drives start/a/b; the adder returns busy/done and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are consumed LSB-first, one bit per clock.
// The result appears all at once with a single done pulse.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  logic [WIDTH-1:0] accum_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             sBit_d;
  logic             carry_d;
  logic             lastBit_d;
  logic [WIDTH-1:0] accum_d;

  // One full-adder step on the current LSBs; the new sum bit enters the accumulator MSB
  // so that after WIDTH shifts the first bit computed has reached bit 0.
  always_comb begin
    sBit_d    = aSh_q[0] ^ bSh_q[0] ^ carry_q;
    carry_d   = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);
    accum_d   = (accum_q >> 1) | (WIDTH'(sBit_d) << (WIDTH - 1));
    lastBit_d = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      accum_q <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            aSh_q   <= bus.a;
            bSh_q   <= bus.b;
            accum_q <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end

        ADD: begin
          aSh_q   <= aSh_q >> 1;
          bSh_q   <= bSh_q >> 1;
          accum_q <= accum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          // sum/cout only ever change here, so no partial result is visible.
          if (lastBit_d) begin
            sum_q   <= accum_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
